// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC/EPC, multi-cycle imem handshake, IF/ID register
// Redirects override in-flight fetches; a killed fetch's late data is dropped on arrival.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] HANDLER_PC = 16'h0002,
  parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        stall_IF,
  input  logic        redirect_D,
  input  logic [15:0] target_D,
  input  logic        redirect_X,
  input  logic [15:0] target_X,
  input  logic        siic,
  input  logic [15:0] siic_pc,
  input  logic        rti,
  input  logic        halt_D,
  output logic [15:0] Instruction,
  output logic [15:0] PC_plus_two,
  output logic        valid,
  output logic [15:0] epc,
  output logic        err
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] epc_q;
  logic [15:0] instr_q;
  logic [15:0] pc2_q;
  logic        valid_q;
  logic        rd_q;
  logic [15:0] addr_q;
  logic        err_q;
  logic        kill_q;
  logic [15:0] hold_q;

  logic        take_siic;
  logic        take_rti;
  logic        take_x;
  logic        take_d;
  logic        redir;
  logic        halt_take;
  logic        accept;
  logic [15:0] redir_pc_d;
  logic [15:0] pc_inc;

  // Decode-sourced redirects are only trusted when decode is not stalled.
  always_comb begin
    take_siic  = siic && !stall_IF;
    take_rti   = rti && !stall_IF && !take_siic;
    take_x     = redirect_X && !take_siic && !take_rti;
    take_d     = redirect_D && !stall_IF && !take_siic && !take_rti && !redirect_X;
    redir      = take_siic || take_rti || take_x || take_d;
    redir_pc_d = target_D;
    if (take_siic) begin
      redir_pc_d = HANDLER_PC;
    end else if (take_rti) begin
      redir_pc_d = epc_q;
    end else if (take_x) begin
      redir_pc_d = target_X;
    end
  end

  assign pc_inc    = pc_q + 16'd2;
  assign accept    = (state_q == FETCH) && rd_q && !imem_stall;
  assign halt_take = halt_D && !stall_IF && !redir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      epc_q   <= 16'h0000;
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= RESET_PC;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      hold_q  <= 16'h0000;
    end else begin
      if (imem_done && (state_q == FETCH || state_q == HOLD)) begin
        err_q <= 1'b1;
      end
      // Bubble by default whenever decode consumes; a delivered word overrides below.
      if (!stall_IF) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
      if (state_q == HALTED) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
        rd_q    <= 1'b0;
      end else if (redir) begin
        pc_q    <= redir_pc_d;
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
        rd_q    <= 1'b1;
        addr_q  <= redir_pc_d;
        if (take_siic) begin
          epc_q <= siic_pc;
        end
        case (state_q)
          FETCH: begin
            if (accept) begin
              state_q <= WAIT;
              kill_q  <= 1'b1;
              rd_q    <= 1'b0;
            end
          end
          WAIT: begin
            if (imem_done) begin
              state_q <= FETCH;
              kill_q  <= 1'b0;
            end else begin
              kill_q <= 1'b1;
              rd_q   <= 1'b0;
            end
          end
          default: state_q <= FETCH;
        endcase
      end else if (halt_take) begin
        state_q <= HALTED;
        rd_q    <= 1'b0;
        kill_q  <= 1'b0;
      end else begin
        case (state_q)
          FETCH: begin
            if (accept) begin
              state_q <= WAIT;
              rd_q    <= 1'b0;
            end else begin
              rd_q   <= 1'b1;
              addr_q <= pc_q;
            end
          end
          WAIT: begin
            if (imem_done) begin
              if (kill_q) begin
                kill_q  <= 1'b0;
                state_q <= FETCH;
                rd_q    <= 1'b1;
                addr_q  <= pc_q;
              end else if (!stall_IF) begin
                instr_q <= imem_data;
                pc2_q   <= pc_inc;
                valid_q <= 1'b1;
                pc_q    <= pc_inc;
                state_q <= FETCH;
                rd_q    <= 1'b1;
                addr_q  <= pc_inc;
              end else begin
                hold_q  <= imem_data;
                state_q <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall_IF) begin
              instr_q <= hold_q;
              pc2_q   <= pc_inc;
              valid_q <= 1'b1;
              pc_q    <= pc_inc;
              state_q <= FETCH;
              rd_q    <= 1'b1;
              addr_q  <= pc_inc;
            end
          end
          default: begin
            rd_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign imem_rd     = rd_q;
  assign imem_addr   = addr_q;
  assign Instruction = instr_q;
  assign PC_plus_two = pc2_q;
  assign valid       = valid_q;
  assign epc         = epc_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
// The model tracks the architectural PC stream; a monitor pops expected words on each delivery.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_done = 1'b0;
  logic        imem_stall = 1'b0;
  logic        stall_IF = 1'b0;
  logic        redirect_D = 1'b0;
  logic [15:0] target_D = 16'h0000;
  logic        redirect_X = 1'b0;
  logic [15:0] target_X = 16'h0000;
  logic        siic = 1'b0;
  logic [15:0] siic_pc = 16'h0000;
  logic        rti = 1'b0;
  logic        halt_D = 1'b0;
  logic [15:0] Instruction;
  logic [15:0] PC_plus_two;
  logic        valid;
  logic [15:0] epc;
  logic        err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_done(imem_done), .imem_stall(imem_stall),
    .stall_IF(stall_IF), .redirect_D(redirect_D), .target_D(target_D),
    .redirect_X(redirect_X), .target_X(target_X), .siic(siic), .siic_pc(siic_pc),
    .rti(rti), .halt_D(halt_D), .Instruction(Instruction), .PC_plus_two(PC_plus_two),
    .valid(valid), .epc(epc), .err(err)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] next_pc = 16'h0000;
  logic [15:0] m_epc = 16'h0000;
  bit          m_halted = 1'b0;
  bit          exp_bubble = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          deliveries = 0;

  int          mem_cnt = 0;
  int          fixed_lat = 2;
  int          stall_pct = 0;
  logic [15:0] mem_paddr = 16'h0000;
  logic [15:0] addr_log[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] r;
    case (a)
      16'h0000: r = 16'h4000;
      16'h0002: r = 16'hC123;
      16'h0004: r = 16'h0000;
      default: begin
        r = a * 16'h9E37;
        r = r ^ 16'h3C5A;
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_pc    = 16'h0000;
    m_epc      = 16'h0000;
    m_halted   = 1'b0;
    exp_bubble = 1'b0;
  endtask

  // Drive one cycle of decode/execute inputs and advance the architectural model.
  task automatic drive(input logic s, input logic rd, input logic [15:0] td,
                       input logic rx, input logic [15:0] tx, input logic sc,
                       input logic [15:0] sp, input logic rt, input logic hl);
    logic        take;
    logic [15:0] tgt;
    @(negedge clk);
    stall_IF = s; redirect_D = rd; target_D = td; redirect_X = rx; target_X = tx;
    siic = sc; siic_pc = sp; rti = rt; halt_D = hl;
    take = 1'b0;
    tgt  = 16'h0000;
    exp_bubble = 1'b0;
    if (!m_halted) begin
      if (sc && !s) begin
        take = 1'b1; tgt = 16'h0002;
      end else if (rt && !s) begin
        take = 1'b1; tgt = m_epc;
      end else if (rx) begin
        take = 1'b1; tgt = tx;
      end else if (rd && !s) begin
        take = 1'b1; tgt = td;
      end
      if (take) begin
        exp_q.delete();
        next_pc = tgt;
        exp_bubble = 1'b1;
        if (sc && !s) m_epc = sp;
      end else if (hl && !s) begin
        exp_q.delete();
        m_halted = 1'b1;
        exp_bubble = 1'b1;
      end
      while (!m_halted && exp_q.size() < 8) begin
        exp_q.push_back({mem_word(next_pc), next_pc + 16'd2});
        next_pc = next_pc + 16'd2;
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_inflight(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      idle();
      #1;
      ok = (mem_cnt > 0);
    end
    if (!ok) tmo(name);
  endtask

  task automatic wait_log(input int n, input string name);
    bit ok;
    ok = (addr_log.size() > n);
    for (int i = 0; i < 60 && !ok; i++) begin
      idle();
      #1;
      ok = (addr_log.size() > n);
    end
    if (!ok) tmo(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    stall_IF = 1'b0; redirect_D = 1'b0; redirect_X = 1'b0; siic = 1'b0; rti = 1'b0; halt_D = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr", Instruction, NOP);
    chk("rst_pc2", PC_plus_two, 16'h0000);
    chk("rst_valid", {15'd0, valid}, 16'h0000);
    chk("rst_rd", {15'd0, imem_rd}, 16'h0000);
    chk("rst_err", {15'd0, err}, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Memory: accepts one request at a time, answers after a fixed or random latency.
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_cnt = 0; imem_done = 1'b0; imem_stall = 1'b0;
      end else begin
        imem_done = 1'b0;
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_done = 1'b1;
            imem_data = mem_word(mem_paddr);
          end
        end
        imem_stall = ($urandom_range(99) < stall_pct);
        if (mem_cnt == 0 && !imem_done && imem_rd && !imem_stall) begin
          lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(3, 1));
          mem_cnt   = lat;
          mem_paddr = imem_addr;
          addr_log.push_back(imem_addr);
        end
      end
    end
  end

  // Monitor: compares decode-register outputs against the scoreboard after each edge.
  initial begin
    logic [15:0] prev_instr, prev_pc2;
    logic        prev_valid;
    exp_t        e;
    prev_instr = NOP; prev_pc2 = 16'h0; prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("err", {15'd0, err}, 16'h0000);
        chk("epc", epc, m_epc);
        if (m_halted) begin
          chk("halt_valid", {15'd0, valid}, 16'h0000);
          chk("halt_rd", {15'd0, imem_rd}, 16'h0000);
        end else if (exp_bubble) begin
          chk("bubble_valid", {15'd0, valid}, 16'h0000);
          chk("bubble_instr", Instruction, NOP);
        end else if (stall_IF) begin
          chk("hold_valid", {15'd0, valid}, {15'd0, prev_valid});
          chk("hold_instr", Instruction, prev_instr);
          chk("hold_pc2", PC_plus_two, prev_pc2);
        end else if (valid) begin
          if (exp_q.size() == 0) begin
            tmo("scoreboard_empty");
          end else begin
            e = exp_q.pop_front();
            chk("deliver_instr", Instruction, e.instr);
            chk("deliver_pc2", PC_plus_two, e.pc2);
            deliveries++;
          end
        end else begin
          chk("idle_instr", Instruction, NOP);
        end
        prev_instr = Instruction; prev_pc2 = PC_plus_two; prev_valid = valid;
      end
    end
  end

  initial begin
    int n;
    bit ok;
    logic s;
    do_reset();

    // Sequential fetch with 2-cycle memory.
    fixed_lat = 2; stall_pct = 0;
    n = addr_log.size();
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      idle();
      ok = (deliveries >= 3);
    end
    if (!ok) tmo("seq_deliveries");
    if (addr_log.size() >= n + 3) begin
      chk("seq_addr0", addr_log[n], 16'h0000);
      chk("seq_addr1", addr_log[n+1], 16'h0002);
      chk("seq_addr2", addr_log[n+2], 16'h0004);
    end else tmo("seq_addr");

    // Decode stall across the data return: word held, no new request.
    wait_inflight("hold_inflight");
    n = addr_log.size();
    repeat (3) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("hold_no_req", 16'(addr_log.size()), 16'(n));
    repeat (4) idle();

    // redirect_D during WAIT.
    wait_inflight("rd_inflight");
    n = addr_log.size();
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_log(n, "rd_log");
    if (addr_log.size() > n) chk("rd_addr", addr_log[n], 16'h0040);

    // X beats D in the same cycle.
    wait_inflight("rx_inflight");
    n = addr_log.size();
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0080, 1'b0, 16'h0, 1'b0, 1'b0);
    wait_log(n, "rx_log");
    if (addr_log.size() > n) chk("rx_addr", addr_log[n], 16'h0080);

    // siic into handler, then rti back to EPC.
    wait_inflight("siic_inflight");
    n = addr_log.size();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b0, 1'b0);
    wait_log(n, "siic_log");
    if (addr_log.size() > n) chk("siic_addr", addr_log[n], 16'h0002);
    repeat (8) idle();
    wait_inflight("rti_inflight");
    n = addr_log.size();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    wait_log(n, "rti_log");
    if (addr_log.size() > n) chk("rti_addr", addr_log[n], 16'h0010);

    // Randomized traffic.
    fixed_lat = 0; stall_pct = 25;
    s = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 30) s = ~s;
      drive(s,
            $urandom_range(99) < 5, 16'($urandom) & 16'hFFFE,
            $urandom_range(99) < 4, 16'($urandom) & 16'hFFFE,
            $urandom_range(99) < 3, 16'($urandom) & 16'hFFFE,
            $urandom_range(99) < 3, 1'b0);
    end
    repeat (4) idle();

    // PC wrap at 0xFFFE.
    fixed_lat = 2; stall_pct = 0;
    wait_inflight("wrap_inflight");
    n = addr_log.size();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      idle();
      ok = valid && (PC_plus_two == 16'h0000);
    end
    if (!ok) tmo("wrap_delivery");
    else chk("wrap_instr", Instruction, mem_word(16'hFFFE));
    wait_log(n + 1, "wrap_log");
    if (addr_log.size() > n + 1) begin
      chk("wrap_addr0", addr_log[n], 16'hFFFE);
      chk("wrap_addr1", addr_log[n+1], 16'h0000);
    end

    // Halt, then reset recovers fetching from RESET_PC.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    repeat (20) idle();
    do_reset();
    n = addr_log.size();
    wait_log(n, "post_rst_log");
    if (addr_log.size() > n) chk("post_rst_addr", addr_log[n], 16'h0000);
    repeat (6) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
